// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  // Which requester owns the RF write port in the current cycle
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_WB   = 2'd1;
  localparam logic [1:0] SEL_FIFO = 2'd2;

  // One buffered long-latency result
  typedef struct packed {
    logic             live;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular buffer of long-latency results with per-entry live bits,
// address-match kill of superseded entries and a pending-register mask.
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = RF_AW,
  parameter int unsigned DW    = RF_DW,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1,
  localparam int unsigned NR   = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [AW-1:0] kill_addr_i,
  output logic          head_live_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic [CW-1:0] count_o,
  output logic [NR-1:0] pending_mask_o
);

  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  // Next pointers, count and live bits from push/pop/kill
  always_comb begin
    live_d  = live_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (kill_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (live_q[i] && (PW'(i) != rd_q) && (addr_q[i] == kill_addr_i)) begin
          live_d[i] = 1'b0;
        end
      end
    end
    if (pop_i) begin
      live_d[rd_q] = 1'b0;
      rd_d         = rd_q + PW'(1);
    end
    // The write slot is never occupied when push is allowed, so setting it
    // after the kill loop keeps a same-cycle enqueue alive.
    if (push_i) begin
      live_d[wr_q] = 1'b1;
      wr_d         = wr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      live_q  <= live_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are only meaningful while the slot is live
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_q] <= push_addr_i;
      data_q[wr_q] <= push_data_i;
    end
  end

  // OR of decoded destinations of every live entry
  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live_q[i]) begin
        pending_mask_o[addr_q[i]] = 1'b1;
      end
    end
  end

  assign head_live_o = live_q[rd_q];
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign count_o     = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between the writeback stage (priority) and a
// FIFO of long-latency results, with a starvation guard for the FIFO head.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  localparam int unsigned CW      = $clog2(DEPTH) + 1,
  localparam int unsigned WW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1),
  localparam int unsigned NR      = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_addr,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic [NR-1:0] pending_mask,
  output logic [CW-1:0] fifo_count
);

  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    sel_c;
  logic          nonempty_c;
  logic          starve_c;
  logic          push_c;
  logic          pop_c;
  logic          kill_c;
  logic          head_live;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  rf_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push_c),
    .push_addr_i    (lu_addr),
    .push_data_i    (lu_data),
    .pop_i          (pop_c),
    .kill_i         (kill_c),
    .kill_addr_i    (wb_addr),
    .head_live_o    (head_live),
    .head_addr_o    (head_addr),
    .head_data_o    (head_data),
    .count_o        (fifo_count),
    .pending_mask_o (pending_mask)
  );

  // Grant selection, write-port drive and FIFO control
  always_comb begin
    sel_c      = SEL_NONE;
    rf_wr      = 1'b0;
    rf_a3      = '0;
    rf_wd      = '0;
    wait_d     = wait_q;
    nonempty_c = (fifo_count != '0);
    starve_c   = nonempty_c && (wait_q == WW'(MAX_WAIT));

    if (nonempty_c && (!wb_valid || starve_c)) begin
      sel_c = SEL_FIFO;
    end else if (wb_valid) begin
      sel_c = SEL_WB;
    end

    case (sel_c)
      SEL_FIFO: begin
        rf_wr = head_live && (head_addr != '0);
        rf_a3 = head_addr;
        rf_wd = head_data;
      end
      SEL_WB: begin
        rf_wr = (wb_addr != '0);
        rf_a3 = wb_addr;
        rf_wd = wb_data;
      end
      default: ;
    endcase

    // Nothing reaches the RF while the block is held in reset
    if (rst) begin
      rf_wr = 1'b0;
    end

    // Head bypass counter, saturating at the forcing threshold
    if (!nonempty_c || (sel_c == SEL_FIFO)) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  assign wb_ready = !starve_c;
  assign lu_ready = (fifo_count < CW'(DEPTH));
  // r0 results are accepted but never buffered
  assign push_c   = lu_valid && lu_ready && (lu_addr != '0);
  assign pop_c    = (sel_c == SEL_FIFO);
  assign kill_c   = (sel_c == SEL_WB);

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a cycle model predicts RF writes
// and status outputs; predicted writes are queued and matched against the
// DUT write port.
module tb_rf_write_arbiter;

  localparam int MAXW = 3;
  localparam int DEP  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_addr, lu_addr;
  logic [31:0] wb_data, lu_data;
  logic        wb_ready, lu_ready, rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] pending_mask;
  logic [1:0]  fifo_count;

  rf_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .lu_valid     (lu_valid),
    .lu_addr      (lu_addr),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .rf_wr        (rf_wr),
    .rf_a3        (rf_a3),
    .rf_wd        (rf_wd),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ment_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  ment_t       mq[$];
  wr_t         sb[$];
  int          m_wait;
  logic [31:0] rf_mem [32];
  bit          last_acc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge
  task automatic cyc(input bit r, input bit wbv, input int wba, input logic [31:0] wbd,
                     input bit luv, input int lua, input logic [31:0] lud);
    bit          ne, starve, hg, wg, ewr, acc;
    logic [4:0]  ea;
    logic [31:0] ed, emask;
    wr_t         w;
    rst = r; wb_valid = wbv; wb_addr = 5'(wba); wb_data = wbd;
    lu_valid = luv; lu_addr = 5'(lua); lu_data = lud;
    @(negedge clk);
    ne     = (mq.size() > 0);
    starve = ne && (m_wait == MAXW);
    hg     = ne && (!wbv || starve);
    wg     = wbv && !hg;
    ewr = 1'b0; ea = '0; ed = '0;
    if (hg) begin
      ewr = mq[0].live; ea = mq[0].addr; ed = mq[0].data;
    end else if (wg) begin
      ewr = (wba != 0); ea = 5'(wba); ed = wbd;
    end
    if (r) ewr = 1'b0;
    emask = '0;
    foreach (mq[i]) if (mq[i].live) emask |= 32'(1) << mq[i].addr;
    chk("wb_ready", 64'(wb_ready), 64'(!starve));
    chk("lu_ready", 64'(lu_ready), 64'(mq.size() < DEP));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pending_mask", 64'(pending_mask), 64'(emask));
    chk("rf_wr", 64'(rf_wr), 64'(ewr));
    if (ewr) begin
      w.a = ea; w.d = ed; sb.push_back(w);
    end
    if (rf_wr === 1'b1) begin
      rf_mem[rf_a3] = rf_wd;
      if (sb.size() == 0) begin
        chk("unexpected_wr", 64'(1), 64'(0));
      end else begin
        w = sb.pop_front();
        chk("rf_a3", 64'(rf_a3), 64'(w.a));
        chk("rf_wd", 64'(rf_wd), 64'(w.d));
      end
    end
    // Model next state
    acc = luv && (mq.size() < DEP) && !r;
    last_acc = acc;
    if (r) begin
      mq.delete();
      m_wait = 0;
    end else begin
      if (wg) begin
        for (int i = 1; i < mq.size(); i++)
          if (mq[i].live && mq[i].addr == 5'(wba)) mq[i].live = 1'b0;
      end
      if (!ne || hg) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
      if (hg) void'(mq.pop_front());
      if (acc && lua != 0) mq.push_back('{1'b1, 5'(lua), lud});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    foreach (rf_mem[i]) rf_mem[i] = '0;
    m_wait = 0;
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1;
    lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 32'h2;
    @(posedge clk); #1;

    // Reset held with both requesters active
    cyc(1, 1, 3, 32'h11, 1, 2, 32'h22);
    cyc(1, 1, 3, 32'h11, 1, 2, 32'h22);

    // Idle FIFO path: r5 written one cycle after enqueue
    cyc(0, 0, 0, 0, 1, 5, 32'h1234);
    chk("pm5_after_enq", 64'(pending_mask[5]), 64'(1));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pm5_after_write", 64'(pending_mask[5]), 64'(0));
    chk("rf5", 64'(rf_mem[5]), 64'h1234);

    // Starvation guard: head r7 bypassed three times, then forced
    cyc(0, 0, 0, 0, 1, 7, 32'hAA);
    for (int i = 0; i < 6; i++) cyc(0, 1, 3 + (i % 4), 32'h100 + 32'(i), 0, 0, 0);
    chk("rf7", 64'(rf_mem[7]), 64'hAA);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Back-pressure and pointer wrap: four rounds of three results
    for (int rnd = 0; rnd < 4; rnd++) begin
      k = 0;
      for (int c = 0; c < 14; c++) begin
        cyc(0, 1, 1 + (c % 3), 32'h200 + 32'(c), k < 3, 10 + k, 32'(rnd * 16 + k));
        if (last_acc && k < 3) k++;
      end
      for (int c = 0; c < 4; c++) cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rf12_round", 64'(rf_mem[12]), 64'(rnd * 16 + 2));
    end

    // Kill on newer write: r4 entry superseded by writeback
    cyc(0, 1, 1, 32'h5, 1, 9, 32'h1);
    cyc(0, 1, 2, 32'h6, 1, 4, 32'h2);
    cyc(0, 1, 4, 32'h3, 0, 0, 0);
    chk("pm4_killed", 64'(pending_mask[4]), 64'(0));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rf4", 64'(rf_mem[4]), 64'h3);
    chk("rf9", 64'(rf_mem[9]), 64'h1);

    // r0 handling
    cyc(0, 1, 0, 32'hFF, 1, 0, 32'hEE);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Random mix with occasional mid-operation reset
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 60) == 0, $urandom % 2, $urandom % 8, $urandom,
          $urandom % 2, $urandom % 8, $urandom);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
